mealy_pattern_multi: RTL and testbench

MEALY_PATTERN_MULTI -- requirements
Module: mealy_pattern_multi

---
 rtl/mealy_pattern_multi.sv | 90 +++++++++
 tb/tb_mealy_pattern_multi.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mealy_pattern_multi.sv
`default_nettype none
// ============================================================================
// Module   : mealy_pattern_multi
// Function : Serial Mealy detector comparing one shared bit history against
//            P loadable N-bit patterns, with saturating per-pattern counters.
// Revision : 1.0 - initial release
// ============================================================================
module mealy_pattern_multi #(
  parameter int N  = 3,
  parameter int P  = 2,
  parameter int CW = 8,
  parameter logic [P*N-1:0] PAT_RST = {3'b111, 3'b001}
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i,
  input  logic            valid_in,
  input  logic            overlap,
  input  logic            load,
  input  logic [2:0]      load_idx,
  input  logic [N-1:0]    load_pattern,
  input  logic            clear_cnt,
  output logic [P-1:0]    o,
  output logic [P*CW-1:0] match_cnt
);

  localparam int FW = (N > 2) ? $clog2(N) : 1;
  localparam logic [FW-1:0] c_fill_full = FW'(N - 1);

  logic [N-2:0]  r_hist;
  logic [FW-1:0] r_fill;
  logic [FW-1:0] w_fill_next;
  logic [N-1:0]  w_window;
  logic          w_full;

  // Current bit is appended to the history so a match is seen with no latency.
  assign w_window = {r_hist, i};
  assign w_full   = (r_fill == c_fill_full);

  always_comb begin
    w_fill_next = r_fill;
    if (!overlap && (|o)) begin
      w_fill_next = '0;
    end else if (r_fill != c_fill_full) begin
      w_fill_next = r_fill + FW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (valid_in) begin
      r_hist <= w_window[N-2:0];
      r_fill <= w_fill_next;
    end
  end

  for (genvar p = 0; p < P; p++) begin : g_chan
    // A load_idx of P or above never equals any channel index, so it is dropped.
    localparam logic [2:0] c_idx = 3'(p);

    logic [N-1:0]  r_pat;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_pat <= PAT_RST[p*N +: N];
      end else if (load && (load_idx == c_idx)) begin
        r_pat <= load_pattern;
      end
    end

    assign o[p] = valid_in & w_full & (w_window == r_pat);

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (clear_cnt) begin
        r_cnt <= '0;
      end else if (o[p] && (r_cnt != {CW{1'b1}})) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign match_cnt[p*CW +: CW] = r_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_mealy_pattern_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_mealy_pattern_multi
// Function : Directed table-driven bench for mealy_pattern_multi (CW=8 and CW=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_pattern_multi;

  typedef struct {
    logic       v;
    logic       b;
    logic       ov;
    logic [1:0] exp;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       i = 1'b0;
  logic       valid_in = 1'b0;
  logic       overlap = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_idx = 3'd0;
  logic [2:0] load_pattern = 3'd0;
  logic       clear_cnt = 1'b0;
  logic [1:0] o;
  logic [1:0] o_s;
  logic [15:0] match_cnt;
  logic [3:0]  match_cnt_s;

  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl[$];

  always #5 clock = ~clock;

  mealy_pattern_multi dut (
    .clock(clock), .reset_n(reset_n), .i(i), .valid_in(valid_in),
    .overlap(overlap), .load(load), .load_idx(load_idx),
    .load_pattern(load_pattern), .clear_cnt(clear_cnt),
    .o(o), .match_cnt(match_cnt)
  );

  mealy_pattern_multi #(.CW(2)) dut_s (
    .clock(clock), .reset_n(reset_n), .i(i), .valid_in(valid_in),
    .overlap(overlap), .load(load), .load_idx(load_idx),
    .load_pattern(load_pattern), .clear_cnt(clear_cnt),
    .o(o_s), .match_cnt(match_cnt_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cnt(input string nm, input int c0, input int c1, input int s0, input int s1);
    chk({nm, " cnt0"}, 32'(match_cnt[7:0]), 32'(c0));
    chk({nm, " cnt1"}, 32'(match_cnt[15:8]), 32'(c1));
    chk({nm, " cnt0_cw2"}, 32'(match_cnt_s[1:0]), 32'(s0));
    chk({nm, " cnt1_cw2"}, 32'(match_cnt_s[3:2]), 32'(s1));
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic step(input logic v, input logic b, input logic ov, input logic [1:0] exp, input string nm);
    valid_in = v;
    i = b;
    overlap = ov;
    #2;
    chk({nm, " o"}, 32'(o), 32'(exp));
    chk({nm, " o_cw2"}, 32'(o_s), 32'(exp));
    @(posedge clock);
    #1;
    load = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic run_tbl(input string lbl);
    for (int k = 0; k < tbl.size(); k++)
      step(tbl[k].v, tbl[k].b, tbl[k].ov, tbl[k].exp, $sformatf("%s[%0d]", lbl, k));
    tbl.delete();
  endtask

  task automatic add(input logic v, input logic b, input logic ov, input logic [1:0] exp);
    vec_t e;
    e.v = v; e.b = b; e.ov = ov; e.exp = exp;
    tbl.push_back(e);
  endtask

  task automatic do_reset(input string nm);
    valid_in = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk({nm, " rst o"}, 32'(o), 32'd0);
    chk_cnt({nm, " rst"}, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state, with a would-be match on the inputs while in reset.
    valid_in = 1'b1;
    i = 1'b1;
    #12;
    chk("por o", 32'(o), 32'd0);
    chk_cnt("por", 0, 0, 0, 0);
    reset_n = 1'b1;
    valid_in = 1'b0;
    @(posedge clock);
    #1;

    // Basic stream, overlap on: patterns are p0=001, p1=111.
    add(1,1,1,2'b00); add(1,1,1,2'b00); add(1,1,1,2'b10); add(1,0,1,2'b00);
    add(1,0,1,2'b00); add(1,1,1,2'b01); add(1,1,1,2'b00); add(1,0,1,2'b00);
    add(1,0,1,2'b00); add(1,1,1,2'b01);
    run_tbl("basic");
    chk_cnt("basic", 2, 1, 2, 1);

    // Same stream with idle cycles; idle inputs would match if not gated.
    do_reset("idle");
    add(1,1,1,2'b00); add(1,1,1,2'b00); add(0,1,1,2'b00); add(1,1,1,2'b10);
    add(0,1,1,2'b00); add(1,0,1,2'b00); add(1,0,1,2'b00); add(0,1,1,2'b00);
    add(1,1,1,2'b01); add(1,1,1,2'b00); add(0,0,1,2'b00); add(1,0,1,2'b00);
    add(1,0,1,2'b00); add(0,1,1,2'b00); add(1,1,1,2'b01);
    run_tbl("idle");
    chk_cnt("idle", 2, 1, 2, 1);

    // Six ones, overlapping.
    do_reset("ov1");
    add(1,1,1,2'b00); add(1,1,1,2'b00); add(1,1,1,2'b10);
    add(1,1,1,2'b10); add(1,1,1,2'b10); add(1,1,1,2'b10);
    run_tbl("ov1");
    chk_cnt("ov1", 0, 4, 0, 3);

    // Six ones, non-overlapping: history restarts after each match.
    do_reset("ov0");
    add(1,1,0,2'b00); add(1,1,0,2'b00); add(1,1,0,2'b10);
    add(1,1,0,2'b00); add(1,1,0,2'b00); add(1,1,0,2'b10);
    run_tbl("ov0");
    chk_cnt("ov0", 0, 2, 0, 2);

    // Saturation of the 2-bit counter, then clear against a match.
    do_reset("sat");
    for (int k = 0; k < 7; k++)
      step(1, 1, 1, (k >= 2) ? 2'b10 : 2'b00, $sformatf("sat[%0d]", k));
    chk_cnt("sat", 0, 5, 0, 3);
    clear_cnt = 1'b1;
    step(1, 1, 1, 2'b10, "clr");
    chk_cnt("clr", 0, 0, 0, 0);
    step(1, 1, 1, 2'b10, "postclr");
    chk_cnt("postclr", 0, 1, 0, 1);

    // Pattern load coinciding with a completion, then an out-of-range load.
    do_reset("load");
    step(1, 1, 1, 2'b00, "load0");
    step(1, 0, 1, 2'b00, "load1");
    load = 1'b1; load_idx = 3'd0; load_pattern = 3'b101;
    step(1, 1, 1, 2'b00, "load2");
    step(1, 0, 1, 2'b00, "load3");
    step(1, 1, 1, 2'b01, "load4");
    load = 1'b1; load_idx = 3'd5; load_pattern = 3'b000;
    add(1,0,1,2'b00); add(1,0,1,2'b00); add(1,0,1,2'b00);
    add(1,1,1,2'b00); add(1,1,1,2'b00); add(1,1,1,2'b10);
    run_tbl("badidx");
    chk_cnt("badidx", 1, 1, 1, 1);

    // Asynchronous reset between edges while a match is being presented.
    do_reset("async");
    step(1, 1, 1, 2'b00, "async0");
    step(1, 1, 1, 2'b00, "async1");
    step(1, 1, 1, 2'b10, "async2");
    valid_in = 1'b1;
    i = 1'b1;
    #2;
    chk("async pre o", 32'(o), 32'(2'b10));
    reset_n = 1'b0;
    #1;
    chk("async now o", 32'(o), 32'd0);
    chk_cnt("async now", 0, 0, 0, 0);
    valid_in = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    step(1, 1, 1, 2'b00, "after0");
    step(1, 1, 1, 2'b00, "after1");
    step(1, 1, 1, 2'b10, "after2");
    chk_cnt("after", 0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
